pack: RTL
=========

# pack

- Serial-to-parallel packer: collects `ARGD` consecutive `ARGW`-bit items from a strobe/ready stream and emits them as one `ARGD*ARGW`-bit word.
- Inverse of the unpacker and sits directly upstream of it: `pack` followed by `unpack` with equal parameters reproduces the original item order.
- Item 0 lands in bits `[ARGW-1:0]`, item k in `[ARGW*k +: ARGW]`.
- Sustains one item per cycle on the input while a completed word waits on the output.

## Interface

Parameters:
- `ARGW`, 8, item width in bits.
- `ARGD`, 2, items per word; must be ≥ 2. Non-powers-of-two are legal.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-low (asserted when 0).
- `arg_stb`  in  1  input item valid.
- `arg_dat`  in  `ARGW`  input item.
- `arg_lst`  in  1  last item of a burst; present only with `PACK_LAST_EN`.
- `arg_rdy`  out  1  input ready.
- `out_stb`  out  1  output word valid.
- `out_dat`  out  `ARGD*ARGW`  packed word.
- `out_cnt`  out  `$clog2(ARGD+1)`  valid items in `out_dat`; present only with `PACK_LAST_EN`.
- `out_rdy`  in  1  downstream ready.

## Operation

- **Transfers.** Input transfer when `arg_stb & arg_rdy`; output transfer when `out_stb & out_rdy`.
- **State:**
  - `idx`: width `$clog2(ARGD)`, range 0..`ARGD-1`, `END = ARGD-1`.
  - accumulator `acc`: `ARGD*ARGW` bits.
  - output register `out_dat`/`out_stb`.
- **Ready.** `arg_rdy = (idx != END) | ~out_stb | out_rdy`. The input stalls only when the item that completes a word arrives while the previous word is still held. `arg_rdy` is combinational on `out_rdy`.
- **Accept with `idx != END`:** `acc[ARGW*idx +: ARGW] <= arg_dat`, then `idx <= idx+1`.
- **Accept with `idx == END`:**
  - `out_dat <= {arg_dat, acc[ARGW*END-1:0]}` and `out_stb <= 1`.
  - `idx <= 0`, and `acc` is cleared to 0.
- **Output drain.** `out_stb` falls after an output transfer unless a new word completes in the same cycle, in which case it stays 1 and `out_dat` is replaced. This is back-to-back with no bubble.
- **Hold.** `out_dat` is held stable while `out_stb & ~out_rdy`.
- **Wrap-around.** `idx` wraps from `END` to 0 only on accept; it never otherwise advances.
- **Reset.** While `rst == 0`: `idx = 0`, `acc = 0`, `out_stb = 0`, `out_dat = 0`, `out_cnt = 0`. A partially filled word is discarded, and so is a pending output word.

## Timing

- Latency: `out_stb` rises the cycle after the final item of a word is accepted.
- Throughput: one item per cycle sustained; one word per `ARGD` cycles when `out_rdy` is held high.
- With `out_rdy` low, up to `END` further items of the next word are accepted before `arg_rdy` drops.
- First cycle after reset release: `arg_rdy = 1`, `out_stb = 0`.

## Configuration

- Macro: `PACK_LAST_EN`.
- **Defined:**
  - Adds the `arg_lst` input and the `out_cnt` output.
  - An accepted item with `arg_lst = 1` completes the word at any `idx`. Remaining upper slices are 0, `out_cnt = idx+1`, and `idx <= 0`.
  - At `idx != END` the lst item has the same ready rule as an `END` item: `arg_rdy` for it requires `~out_stb | out_rdy`.
  - Full words report `out_cnt = ARGD`.
- **Undefined:** neither port exists, and every word carries exactly `ARGD` items.

## Structure

- Shared package: the stream handshake width helper (`clog2`-based index width) and the `ARGW`/`ARGD` defaults, shared with `unpack`.
- `END` and the index width are local parameters.
- No sub-module; a flat single module is natural.

## Test plan

All scenarios use `ARGW=8`, `ARGD=2` unless stated.

- **Reset then stream.** Send 0x11, 0x22 with `out_rdy=1` → one cycle later `out_stb=1`, `out_dat=0x2211`; next cycle `out_stb=0`.
- **Continuous stream.** Send 0x01..0x08 back-to-back with `out_rdy=1` → words 0x0201, 0x0403, 0x0605, 0x0807 on consecutive odd cycles; `arg_rdy` never drops.
- **Backpressure.** Hold `out_rdy=0`, send 0xA1, 0xA2, 0xB1, 0xB2:
  - 0xB1 is accepted; `arg_rdy=0` while 0xB2 is offered; `out_dat` stays 0xA2A1.
  - Raise `out_rdy` → 0xA2A1 transfers, 0xB2 is accepted the same cycle, then 0xB2B1 follows without a bubble.
- **Mid-word reset.** Accept 0x55, assert `rst=0` for one cycle, then send 0x66, 0x77 → output 0x7766; 0x55 never appears.
- **`ARGD=3`, `ARGW=4`.** Send 1, 2, 3 → `out_dat=0x321`; `idx` wraps to 0.
- **`PACK_LAST_EN`.** Send 0x33 with `arg_lst=1` → `out_dat=0x0033`, `out_cnt=1`. Then 0x44, 0x55 with `arg_lst=0`,1 → `0x5544`, `out_cnt=2`.

Source files
------------

// File: rtl/pack_pkg.sv
// Shared stream helpers for the pack/unpack pair: default item geometry and index/count widths.
package pack_pkg;

    localparam int unsigned ARGW_DEF = 8;
    localparam int unsigned ARGD_DEF = 2;

    // Width of a slot index running 0..depth-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Width of an item count running 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pack.sv
// Serial-to-parallel packer: ARGD items of ARGW bits become one word, item 0 in the LSBs.
// Optional PACK_LAST_EN adds arg_lst (short-word terminator) and out_cnt (items in word).
module pack
    import pack_pkg::*;
#(
    parameter int unsigned ARGW = ARGW_DEF,
    parameter int unsigned ARGD = ARGD_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arg_stb,
    input  logic [ARGW-1:0]                arg_dat,
`ifdef PACK_LAST_EN
    input  logic                           arg_lst,
`endif
    output logic                           arg_rdy,
    output logic                           out_stb,
    output logic [ARGD*ARGW-1:0]           out_dat,
`ifdef PACK_LAST_EN
    output logic [cnt_width(ARGD)-1:0]     out_cnt,
`endif
    input  logic                           out_rdy
);

    localparam int unsigned IW = idx_width(ARGD);
    localparam int unsigned CW = cnt_width(ARGD);
    localparam int unsigned W  = ARGD * ARGW;
    localparam logic [IW-1:0] END = IW'(ARGD - 1);

    logic [IW-1:0] idx_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  out_dat_q;
    logic          out_stb_q;
    logic [CW-1:0] out_cnt_q;

    logic          complete;
    logic          accept;
    logic [W-1:0]  word;

    always_comb begin
`ifdef PACK_LAST_EN
        complete = (idx_q == END) | arg_lst;
`else
        complete = (idx_q == END);
`endif
        // Only a word-completing item needs the output register free.
        arg_rdy = ~complete | ~out_stb_q | out_rdy;
        accept  = arg_stb & arg_rdy;
    end

    // Slots at or above idx are zero in acc, so a short word gets zero upper slices for free.
    always_comb begin
        word = acc_q;
        for (int k = 0; k < int'(ARGD); k++) begin
            if (idx_q == IW'(k)) begin
                word[ARGW*k +: ARGW] = arg_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q     <= '0;
            acc_q     <= '0;
            out_stb_q <= 1'b0;
            out_dat_q <= '0;
            out_cnt_q <= '0;
        end else begin
            if (out_stb_q && out_rdy) begin
                out_stb_q <= 1'b0;
            end
            if (accept) begin
                if (complete) begin
                    out_dat_q <= word;
                    out_stb_q <= 1'b1;
                    out_cnt_q <= CW'(idx_q) + CW'(1);
                    idx_q     <= '0;
                    acc_q     <= '0;
                end else begin
                    acc_q <= word;
                    idx_q <= idx_q + IW'(1);
                end
            end
        end
    end

    assign out_stb = out_stb_q;
    assign out_dat = out_dat_q;
`ifdef PACK_LAST_EN
    assign out_cnt = out_cnt_q;
`else
    // Count is only exported with the last-item feature; keep the register tidy otherwise.
    logic unused_cnt;
    assign unused_cnt = ^out_cnt_q;
`endif

endmodule
